nasti_stream_pkt_fifo: RTL and testbench
========================================

# nasti_stream_pkt_fifo

- Store-and-forward packet FIFO for a single NASTI-stream lane.
- Sits directly downstream of each crossbar output port, between the crossbar `slave` lane and the consuming peripheral. A downstream device therefore never sees a partial packet stalled mid-transfer by crossbar arbitration.
- Holds beats until `t_last` arrives, then presents the whole packet back-to-back.
- Optional error-packet discard and a cut-through fallback for oversize packets.

## Interface

Parameters:
- `DEPTH`, 16: beat entries; power of two, ≥2.
- `ID_WIDTH`, 1: `t_id` width.
- `DEST_WIDTH`, 1: `t_dest` width.
- `USER_WIDTH`, 1: `t_user` width.
- `DATA_WIDTH`, 64: `t_data` width; `t_strb`/`t_keep` are `DATA_WIDTH/8`.

Ports:
- `aclk`  in  1  clock; single clock domain.
- `areset`  in  1  reset, synchronous, active-high.
- `src`  `nasti_stream_channel.slave`  lane 0  inbound beats (`t_valid`/`t_ready`/`t_data`/`t_strb`/`t_keep`/`t_last`/`t_id`/`t_dest`/`t_user`).
- `dest`  `nasti_stream_channel.master`  lane 0  outbound beats, same fields.
- `pkt_count`  out  $clog2(DEPTH)+1  complete packets currently stored.
- `drop_count`  out  16  packets discarded; saturating. Present only with `NASTI_STREAM_PKT_FIFO_DROP_EN`.

## Operation

Storage:
- Circular buffer of `DEPTH` entries, each {data, strb, keep, last, id, dest, user}.

Pointers, each `$clog2(DEPTH)+1` bits with the MSB as wrap bit:
- `wr_ptr`: next write slot.
- `cm_ptr`: end of the last committed packet.
- `rd_ptr`: next read slot.

Flags and handshakes:
- `full` = (`wr_ptr` − `rd_ptr`) == `DEPTH`. Empty-for-read = (`rd_ptr` == `cm_ptr`) and not cut-through.
- `src.t_ready` = !`full`. A write occurs on `src.t_valid && src.t_ready`; `wr_ptr` increments.
- A write with `t_last`=1 commits: `cm_ptr` ← `wr_ptr`+1, and `pkt_count` increments.
- `dest.t_valid` = (`rd_ptr` != `cm_ptr`) or (`cut` and `rd_ptr` != `wr_ptr`).
- `dest` fields come from entry `rd_ptr` (first-word-fall-through). A read on `dest.t_valid && dest.t_ready` increments `rd_ptr`. Reading a beat with last=1 decrements `pkt_count`.
- Simultaneous commit and last-beat read leave `pkt_count` unchanged.

Write state machine:
- `IDLE`: no packet open. Any accepted beat → `FILL`, or straight back to `IDLE` if it carries `t_last`.
- `FILL`: packet open. Accepted beat with `t_last` → `IDLE`. If `full` and `pkt_count`==0 (oversize packet) → `CUT`.
- `CUT`: `cut`=1. The reader drains uncommitted beats, so the packet streams through. Accepted beat with `t_last` → commit, `cut`←0 → `IDLE`. `cm_ptr` tracks `wr_ptr` on every write while in `CUT`.

`dest` signals stay stable while `t_valid && !t_ready`; the rule is guaranteed because the entry at `rd_ptr` cannot be overwritten.

## Timing

- Latency: a `t_last` beat accepted in cycle N makes the packet's first beat visible on `dest` in cycle N+1.
- Throughput: one beat in and one beat out per cycle.
- Reset values: all pointers 0, state `IDLE`, `cut` 0, `src.t_ready` 1 from the first cycle after reset, `dest.t_valid` 0, `dest` data fields 0 (memory contents don't care, gated by valid), `pkt_count` 0, `drop_count` 0.
- Reset asserted mid-packet discards all contents, including committed packets, in the same edge.
- Wrap-around: pointers wrap modulo 2·`DEPTH`. Full and empty detection use the wrap bit.

## Configuration

`NASTI_STREAM_PKT_FIFO_DROP_EN`:
- Defined:
  - A packet whose `t_last` beat has `t_user[0]`=1 is discarded: `wr_ptr` ← `cm_ptr`, no commit, `pkt_count` unchanged, `drop_count` +1 (saturating at 0xFFFF).
  - A packet already in `CUT` cannot be discarded; it is forwarded as-is and not counted.
- Undefined: `t_user` is passed through untouched, every packet is committed, and the `drop_count` port is absent.

## Structure

- `nasti_stream_pkg` gains:
  - the `nasti_stream_beat_t` packed struct parameterised by the width localparams;
  - the `pkt_fifo_state_e` enum (`IDLE`, `FILL`, `CUT`).
- One sub-module, `nasti_stream_pkt_fifo_ram`: a 1-write/1-async-read beat array. It keeps the storage swappable for distributed or block RAM.
- Pointer and state logic stay in the top module.

## Test plan

- Single packet, `DEPTH`=16: 4 beats, data 0x1..0x4, last on beat 4 at cycle 10 → `dest.t_valid` rises cycle 11, beats emerge back-to-back 0x1..0x4, `pkt_count` 1→0.
- Back-pressure: `dest.t_ready`=0. Write three 5-beat packets (15 beats) → `pkt_count`=3 and `src.t_ready` stays 1. The 16th beat fills the FIFO and drops `src.t_ready` the following cycle. Release `dest.t_ready` → all beats arrive in order with fields stable during stalls.
- Oversize: 20-beat packet into an empty `DEPTH`=16 FIFO → `CUT` entered at 16 beats, `dest` streams beats 1..20 in order, last on beat 20, `pkt_count` returns to 0.
- Simultaneous commit/read: a packet's last beat is read in the same cycle a new packet's last beat is written → `pkt_count` unchanged; pointers wrap past 32 without data corruption.
- Drop (macro on): 3-beat packet with `t_user[0]`=1 on last, then a good 2-beat packet → only the 2 good beats appear on `dest`, `drop_count`=1.
- Reset mid-packet: assert `areset` after 2 of 4 beats → next cycle `dest.t_valid`=0, `pkt_count`=0, `src.t_ready`=1. A new packet then passes normally.

Source files
------------

// File: rtl/nasti_stream_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : nasti_stream_pkg                                          |
// | Purpose  : Shared beat layout, write-FSM state encoding and a width  |
// |            helper for the NASTI-stream packet FIFO.                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package nasti_stream_pkg;

  localparam int c_id_width   = 1;
  localparam int c_dest_width = 1;
  localparam int c_user_width = 1;
  localparam int c_data_width = 64;
  localparam int c_strb_width = c_data_width / 8;

  // One stored beat, in the same field order the FIFO packs into its RAM.
  typedef struct packed {
    logic [c_data_width-1:0] data;
    logic [c_strb_width-1:0] strb;
    logic [c_strb_width-1:0] keep;
    logic                    last;
    logic [c_id_width-1:0]   id;
    logic [c_dest_width-1:0] dest;
    logic [c_user_width-1:0] user;
  } nasti_stream_beat_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    CUT  = 2'd2
  } pkt_fifo_state_e;

  // Bits needed to hold one beat for an arbitrary lane configuration.
  function automatic int beat_width(input int data_w, input int id_w,
                                    input int dest_w, input int user_w);
    return data_w + 2 * (data_w / 8) + 1 + id_w + dest_w + user_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nasti_stream_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : nasti_stream_channel                                      |
// | Purpose  : One NASTI-stream lane (valid/ready plus payload fields).  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface nasti_stream_channel #(
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1,
  parameter int DATA_WIDTH = 64
);
  logic                    t_valid;
  logic                    t_ready;
  logic [DATA_WIDTH-1:0]   t_data;
  logic [DATA_WIDTH/8-1:0] t_strb;
  logic [DATA_WIDTH/8-1:0] t_keep;
  logic                    t_last;
  logic [ID_WIDTH-1:0]     t_id;
  logic [DEST_WIDTH-1:0]   t_dest;
  logic [USER_WIDTH-1:0]   t_user;

  modport master (output t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
                  input  t_ready);
  modport slave  (input  t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
                  output t_ready);
endinterface
`default_nettype wire

// File: rtl/nasti_stream_pkt_fifo_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : nasti_stream_pkt_fifo_ram                                 |
// | Purpose  : 1-write / 1-asynchronous-read beat array backing the      |
// |            packet FIFO; isolated so it can be mapped to distributed  |
// |            or block RAM without touching the pointer logic.          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module nasti_stream_pkt_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port; contents are never reset, readers gate them with valid.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/nasti_stream_pkt_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : nasti_stream_pkt_fifo                                     |
// | Purpose  : Store-and-forward packet FIFO for one NASTI-stream lane.  |
// |            Beats are held until t_last, then released back-to-back.  |
// |            Packets larger than the buffer fall back to cut-through.  |
// |            Define NASTI_STREAM_PKT_FIFO_DROP_EN to discard packets   |
// |            whose last beat carries t_user[0]=1 and count them on     |
// |            drop_count.                                               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module nasti_stream_pkt_fifo
  import nasti_stream_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1,
  parameter int DATA_WIDTH = 64
) (
  input  logic                     aclk,
  input  logic                     areset,
  nasti_stream_channel.slave       src,
  nasti_stream_channel.master      dest,
  output logic [$clog2(DEPTH):0]   pkt_count
`ifdef NASTI_STREAM_PKT_FIFO_DROP_EN
  ,
  output logic [15:0]              drop_count
`endif
);

  localparam int c_aw     = $clog2(DEPTH);
  localparam int c_strb_w = DATA_WIDTH / 8;
  localparam int c_beat_w = beat_width(DATA_WIDTH, ID_WIDTH, DEST_WIDTH, USER_WIDTH);
  localparam logic [c_aw:0] c_depth = DEPTH[c_aw:0];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [c_aw:0]   r_wr_ptr, r_cm_ptr, r_rd_ptr;
  logic [c_aw:0]   r_pkt_count;
  pkt_fifo_state_e r_state;
  logic            r_cut;

  logic w_full, w_wr_en, w_rd_en, w_valid;
  logic w_commit, w_drop, w_enter_cut, w_cut_wr;

  logic [c_beat_w-1:0]   w_wdata, w_rdata;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [c_strb_w-1:0]   w_rd_strb, w_rd_keep;
  logic                  w_rd_last;
  logic [ID_WIDTH-1:0]   w_rd_id;
  logic [DEST_WIDTH-1:0] w_rd_dest;
  logic [USER_WIDTH-1:0] w_rd_user;

  assign w_full      = (r_wr_ptr - r_rd_ptr) == c_depth;
  assign src.t_ready = !w_full;
  assign w_wr_en     = src.t_valid && !w_full;

  // Committed beats are readable; while cutting through, everything written is.
  assign w_valid = (r_rd_ptr != r_cm_ptr) || (r_cut && (r_rd_ptr != r_wr_ptr));
  assign w_rd_en = w_valid && dest.t_ready;

  assign w_cut_wr    = w_wr_en && (r_state == CUT);
  // An open packet that alone fills the buffer can never commit: stream it.
  assign w_enter_cut = (r_state == FILL) && w_full && (r_pkt_count == '0);

`ifdef NASTI_STREAM_PKT_FIFO_DROP_EN
  assign w_drop = w_wr_en && src.t_last && src.t_user[0] && (r_state != CUT);
`else
  assign w_drop = 1'b0;
`endif
  assign w_commit = w_wr_en && src.t_last && !w_drop;

  assign w_wdata = {src.t_data, src.t_strb, src.t_keep, src.t_last,
                    src.t_id, src.t_dest, src.t_user};

  nasti_stream_pkt_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (c_beat_w)
  ) u_ram (
    .clk     (aclk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr[c_aw-1:0]),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr[c_aw-1:0]),
    .o_rdata (w_rdata)
  );

  assign {w_rd_data, w_rd_strb, w_rd_keep, w_rd_last,
          w_rd_id, w_rd_dest, w_rd_user} = w_rdata;

  // Payload is zeroed whenever nothing is presented so stale RAM never leaks.
  assign dest.t_valid = w_valid;
  assign dest.t_data  = w_valid ? w_rd_data : '0;
  assign dest.t_strb  = w_valid ? w_rd_strb : '0;
  assign dest.t_keep  = w_valid ? w_rd_keep : '0;
  assign dest.t_last  = w_valid && w_rd_last;
  assign dest.t_id    = w_valid ? w_rd_id   : '0;
  assign dest.t_dest  = w_valid ? w_rd_dest : '0;
  assign dest.t_user  = w_valid ? w_rd_user : '0;

  // Pointer and packet-count bookkeeping.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wr_ptr    <= '0;
      r_cm_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_pkt_count <= '0;
    end else begin
      if (w_drop)       r_wr_ptr <= r_cm_ptr;
      else if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;

      // Entering cut-through releases the beats already buffered.
      if (w_commit || w_cut_wr) r_cm_ptr <= r_wr_ptr + 1'b1;
      else if (w_enter_cut)     r_cm_ptr <= r_wr_ptr;

      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;

      case ({w_commit, w_rd_en && w_rd_last})
        2'b10:   r_pkt_count <= r_pkt_count + 1'b1;
        2'b01:   r_pkt_count <= r_pkt_count - 1'b1;
        default: r_pkt_count <= r_pkt_count;
      endcase
    end
  end

  // Write-side packet state machine; cut is its registered output.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= IDLE;
      r_cut   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_wr_en && !src.t_last) r_state <= FILL;
        FILL: begin
          if (w_wr_en && src.t_last) begin
            r_state <= IDLE;
          end else if (w_enter_cut) begin
            r_state <= CUT;
            r_cut   <= 1'b1;
          end
        end
        CUT: begin
          if (w_wr_en && src.t_last) begin
            r_state <= IDLE;
            r_cut   <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cut   <= 1'b0;
        end
      endcase
    end
  end

  assign pkt_count = r_pkt_count;

`ifdef NASTI_STREAM_PKT_FIFO_DROP_EN
  logic [15:0] r_drop_count;

  // Saturating count of discarded packets.
  always_ff @(posedge aclk) begin
    if (areset)                                r_drop_count <= '0;
    else if (w_drop && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 1'b1;
  end

  assign drop_count = r_drop_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nasti_stream_pkt_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_nasti_stream_pkt_fifo                                  |
// | Purpose  : Scoreboard bench for the NASTI-stream packet FIFO.        |
// |            Honours NASTI_STREAM_PKT_FIFO_DROP_EN when defined.       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_nasti_stream_pkt_fifo;
  import nasti_stream_pkg::*;

  localparam int DEPTH = 16;
`ifdef NASTI_STREAM_PKT_FIFO_DROP_EN
  localparam bit c_drop_en = 1'b1;
  logic [15:0] drop_count;
`else
  localparam bit c_drop_en = 1'b0;
`endif

  logic aclk   = 1'b0;
  logic areset = 1'b1;
  logic [$clog2(DEPTH):0] pkt_count;

  always #5 aclk = ~aclk;

  nasti_stream_channel #(.ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1), .DATA_WIDTH(64)) src_if ();
  nasti_stream_channel #(.ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1), .DATA_WIDTH(64)) dest_if ();

  nasti_stream_pkt_fifo #(
    .DEPTH(DEPTH), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1), .DATA_WIDTH(64)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .src        (src_if),
    .dest       (dest_if),
    .pkt_count  (pkt_count)
`ifdef NASTI_STREAM_PKT_FIFO_DROP_EN
    ,
    .drop_count (drop_count)
`endif
  );

  int checks = 0;
  int fails  = 0;
  int out_count = 0;
  int exp_drops = 0;
  int ready_mode = 1;   // 0: hold off, 1: always ready, 2: random
  nasti_stream_beat_t exp_q[$];
  nasti_stream_beat_t pend_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Sink ready generator.
  initial begin
    dest_if.t_ready = 1'b0;
    forever begin
      @(posedge aclk); #1;
      case (ready_mode)
        0:       dest_if.t_ready = 1'b0;
        1:       dest_if.t_ready = 1'b1;
        default: dest_if.t_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: pops the scoreboard on every transfer, checks stalls hold.
  nasti_stream_beat_t act, held, want;
  bit stalled = 1'b0;
  always @(negedge aclk) begin
    if (areset) begin
      stalled = 1'b0;
    end else begin
      act = '{data: dest_if.t_data, strb: dest_if.t_strb, keep: dest_if.t_keep,
              last: dest_if.t_last, id: dest_if.t_id, dest: dest_if.t_dest,
              user: dest_if.t_user};
      if (stalled) begin
        check("stall_valid", dest_if.t_valid, 1'b1);
        check("stall_fields", act, held);
      end
      if (dest_if.t_valid && dest_if.t_ready) begin
        out_count++;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_beat: got %0h, required no beat", act);
        end else begin
          want = exp_q.pop_front();
          check("beat", act, want);
        end
      end
      stalled = dest_if.t_valid && !dest_if.t_ready;
      held    = act;
    end
  end

  // Reference model: a packet is forwarded whole unless it is flagged for
  // discard, discard is enabled, and it fits the buffer (longer ones stream).
  task automatic build_pkt(input int len, input bit drop, input bit seq, input bit keep_exp);
    nasti_stream_beat_t b;
    bit dropped;
    dropped = c_drop_en && drop && (len <= DEPTH);
    for (int i = 0; i < len; i++) begin
      b.data = seq ? 64'(i + 1) : {$urandom, $urandom};
      b.strb = 8'($urandom);
      b.keep = 8'($urandom);
      b.last = (i == len - 1);
      b.id   = 1'($urandom);
      b.dest = 1'($urandom);
      b.user = (i == len - 1) ? drop : 1'($urandom);
      pend_q.push_back(b);
      if (keep_exp && !dropped) exp_q.push_back(b);
    end
    if (keep_exp && dropped) exp_drops++;
  endtask

  task automatic send_pending(input int n);
    nasti_stream_beat_t b;
    int w;
    for (int k = 0; k < n && pend_q.size() > 0; k++) begin
      b = pend_q.pop_front();
      src_if.t_valid = 1'b1;
      src_if.t_data  = b.data;
      src_if.t_strb  = b.strb;
      src_if.t_keep  = b.keep;
      src_if.t_last  = b.last;
      src_if.t_id    = b.id;
      src_if.t_dest  = b.dest;
      src_if.t_user  = b.user;
      w = 0;
      do begin
        @(negedge aclk);
        w++;
      end while (!src_if.t_ready && w < 5000);
      if (!src_if.t_ready) begin
        checks++;
        fails++;
        $display("FAIL src_timeout: got t_ready 0, required 1 within 5000 cycles");
      end
      @(posedge aclk); #1;
      src_if.t_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int w = 0;
    while ((exp_q.size() != 0 || dest_if.t_valid) && w < 5000) begin
      @(posedge aclk); #2;
      w++;
    end
    check(name, {exp_q.size() == 0, dest_if.t_valid}, 2'b10);
  endtask

  task automatic set_mode(input int m);
    ready_mode = m;
    @(posedge aclk); #2;
  endtask

  initial begin
    int o0;
    src_if.t_valid = 1'b0;
    src_if.t_data  = '0;
    src_if.t_strb  = '0;
    src_if.t_keep  = '0;
    src_if.t_last  = 1'b0;
    src_if.t_id    = '0;
    src_if.t_dest  = '0;
    src_if.t_user  = '0;

    // Reset state
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    check("reset_src_ready", src_if.t_ready, 1'b1);
    check("reset_dest_valid", dest_if.t_valid, 1'b0);
    check("reset_dest_data", dest_if.t_data, 64'h0);
    check("reset_pkt_count", pkt_count, 0);
`ifdef NASTI_STREAM_PKT_FIFO_DROP_EN
    check("reset_drop_count", drop_count, 0);
`endif

    // Single packet: first beat visible the cycle after t_last is taken
    set_mode(1);
    build_pkt(4, 1'b0, 1'b1, 1'b1);
    send_pending(3);
    check("lat_before_last", dest_if.t_valid, 1'b0);
    send_pending(1);
    check("lat_valid", dest_if.t_valid, 1'b1);
    check("lat_pkt_count", pkt_count, 1);
    check("lat_first_data", dest_if.t_data, 64'h1);
    wait_drain("lat_drain");
    check("lat_pkt_count_end", pkt_count, 0);

    // Back-pressure until full
    set_mode(0);
    for (int p = 0; p < 3; p++) begin
      build_pkt(5, 1'b0, 1'b0, 1'b1);
      send_pending(5);
    end
    check("bp_pkt_count", pkt_count, 3);
    check("bp_src_ready", src_if.t_ready, 1'b1);
    build_pkt(2, 1'b0, 1'b0, 1'b1);
    send_pending(1);
    check("bp_full_ready", src_if.t_ready, 1'b0);
    set_mode(2);
    send_pending(1);
    wait_drain("bp_drain");
    check("bp_pkt_count_end", pkt_count, 0);

    // Oversize packet streams through; flagged for discard but must survive
    set_mode(1);
    o0 = out_count;
    build_pkt(20, 1'b1, 1'b1, 1'b1);
    send_pending(19);
    check("cut_streaming", (out_count - o0) > 0, 1'b1);
    send_pending(1);
    wait_drain("cut_drain");
    check("cut_pkt_count_end", pkt_count, 0);

    // Commit and last-beat read in the same cycle, pointers wrap repeatedly
    for (int p = 0; p < 40; p++) begin
      build_pkt(2, 1'b0, 1'b0, 1'b1);
      send_pending(2);
      check("sim_pkt_count", pkt_count, 1);
    end
    wait_drain("sim_drain");
    check("sim_pkt_count_end", pkt_count, 0);

    // Randomized traffic and discard
    set_mode(2);
    for (int p = 0; p < 60; p++) begin
      int len;
      len = $urandom_range(1, 8);
      build_pkt(len, ($urandom_range(0, 3) == 0), 1'b0, 1'b1);
      send_pending(len);
      repeat ($urandom_range(0, 2)) begin
        @(posedge aclk); #1;
      end
    end
    build_pkt(3, 1'b1, 1'b0, 1'b1);
    send_pending(3);
    build_pkt(2, 1'b0, 1'b0, 1'b1);
    send_pending(2);
    wait_drain("rand_drain");
    check("rand_pkt_count_end", pkt_count, 0);
`ifdef NASTI_STREAM_PKT_FIFO_DROP_EN
    check("drop_count", drop_count, exp_drops);
`endif

    // Reset mid-packet with a committed packet still queued
    set_mode(0);
    build_pkt(2, 1'b0, 1'b0, 1'b0);
    send_pending(2);
    build_pkt(4, 1'b0, 1'b0, 1'b0);
    send_pending(2);
    pend_q.delete();
    check("prerst_valid", dest_if.t_valid, 1'b1);
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    exp_drops = 0;
    check("rst_dest_valid", dest_if.t_valid, 1'b0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_src_ready", src_if.t_ready, 1'b1);
`ifdef NASTI_STREAM_PKT_FIFO_DROP_EN
    check("rst_drop_count", drop_count, exp_drops);
`endif
    set_mode(1);
    build_pkt(3, 1'b0, 1'b1, 1'b1);
    send_pending(3);
    wait_drain("post_rst_drain");
    check("post_rst_pkt_count", pkt_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
